// File: rtl/playback_sequencer.sv
// Plays back a stored colour sequence on one-hot LEDs, paced by an external
// flash timer tick, with a fixed number of dark ticks between colours.
module playback_sequencer #(
  parameter int unsigned MAX_LEN   = 33,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] round_len,
  input  logic       tick,
  input  logic [1:0] colour_i,
  output logic [5:0] rd_addr,
  output logic [2:0] speed_o,
  output logic       load_speed,
  output logic [3:0] led_o,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);
  localparam logic [1:0] GAP_C     = 2'(GAP_TICKS);

  state_t     state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [5:0] addr_q, addr_d;
  logic [2:0] speed_q, speed_d;
  logic [1:0] gap_q, gap_d;
  logic       load_q, load_d;
  logic       done_q, done_d;
  logic [3:0] led_q, led_d;
  logic [5:0] len_clamp;
  logic       last_colour;

  function automatic logic [2:0] speed_of(input logic [5:0] n);
    logic [2:0] s;
    if (n <= 6'd4)       s = 3'd0;
    else if (n <= 6'd8)  s = 3'd1;
    else if (n <= 6'd16) s = 3'd2;
    else if (n <= 6'd24) s = 3'd3;
    else                 s = 3'd4;
    return s;
  endfunction

  always_comb begin
    len_clamp   = (round_len > MAX_LEN_C) ? MAX_LEN_C : round_len;
    last_colour = (addr_q == (len_q - 6'd1));
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    speed_d = speed_q;
    gap_d   = gap_q;
    led_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          len_d   = len_clamp;
          speed_d = speed_of(len_clamp);
          addr_d  = '0;
          gap_d   = '0;
        end
      end
      S_LOAD: begin
        addr_d  = '0;
        gap_d   = '0;
        state_d = (len_q == '0) ? S_DONE : S_ON;
      end
      S_ON: begin
        // LED follows the colour one cycle after entering ON, and goes
        // dark on the same edge that leaves ON.
        if (tick) state_d = S_GAP;
        else      led_d   = 4'b0001 << colour_i;
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == (GAP_C - 2'd1)) begin
            gap_d = '0;
            if (last_colour) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 6'd1;
              state_d = S_ON;
            end
          end else begin
            gap_d = gap_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      gap_d   = '0;
      led_d   = '0;
    end

    load_d = (state_d == S_LOAD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      speed_q <= '0;
      gap_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      speed_q <= speed_d;
      gap_q   <= gap_d;
      load_q  <= load_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    rd_addr    = addr_q;
    speed_o    = speed_q;
    load_speed = load_q;
    led_o      = led_q;
    done       = done_q;
    busy       = (state_q != S_IDLE);
  end

endmodule
